// File: rtl/cpu_pkg.sv
// Shared constants and FSM state type for the direct-mapped data cache controller.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned INDEX_W   = 5;
  localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WSEL_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_FILL      = 2'd3
  } dcache_state_t;

  // Clears the byte offset so the address names a whole line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and backing-memory-side signals of the data cache, grouped in one bundle.
// slave: the cache controller.  master: the pipeline and memory environment around it.
interface dcache_controller_if #(
  parameter int unsigned LINE_BITS = cpu_pkg::LINE_BITS
);

  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic                 cpu_MemRead_i;
  logic                 cpu_MemWrite_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Direct-mapped cache storage: tag and data arrays plus valid/dirty bits,
// with one combinational read port and one synchronous write port.
module dcache_sram
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned TAG_BITS  = ADDR_W - OFFSET_W - IDX_W,
  parameter int unsigned LINE_BITS = cpu_pkg::LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 wr_dirty
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // Only the status bits are reset; stale tags/data are harmless once valid is clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data cache controller.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_BITS = cpu_pkg::LINE_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.slave  bus,
`ifdef DCACHE_STATS_EN
  output logic [31:0]         hit_count_o,
  output logic [31:0]         miss_count_o,
`endif
  output dcache_state_t       dbg_state
);

  localparam int unsigned IDX_W    = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = ADDR_W - OFFSET_W - IDX_W;

  // Handshake: the CPU holds its request stable while cpu_stall_o=1. Towards memory,
  // mem_enable_o with mem_write_o/mem_addr_o/mem_data_o stays stable until the
  // one-cycle mem_ack_i; an ack seen outside WRITEBACK/ALLOCATE is ignored.

  dcache_state_t state, state_nx;

  logic [IDX_W-1:0]     index;
  logic [TAG_BITS-1:0]  tag;
  logic [WSEL_W-1:0]    wsel;
  logic                 req;
  logic                 is_store;
  logic                 hit;

  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 sram_we;
  logic [TAG_BITS-1:0]  wr_tag;
  logic [LINE_BITS-1:0] wr_line;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] merged_line;
  logic [LINE_BITS-1:0] fill_buf;

  logic [31:0]          cpu_data;
  logic                 cpu_stall;
  logic                 mem_enable;
  logic                 mem_write;
  logic [31:0]          mem_addr;
  logic                 unused_addr_bits;

  assign index            = bus.cpu_addr_i[OFFSET_W +: IDX_W];
  assign tag              = bus.cpu_addr_i[ADDR_W-1 -: TAG_BITS];
  assign wsel             = bus.cpu_addr_i[OFFSET_W-1:2];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  // A simultaneous read and write request is handled as a store.
  assign is_store = bus.cpu_MemWrite_i;
  assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign hit      = rd_valid && (rd_tag == tag);

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (sram_we),
    .wr_index (index),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line),
    .wr_dirty (wr_dirty)
  );

  always_comb begin
    merged_line = rd_line;
    merged_line[wsel*WORD_W +: WORD_W] = bus.cpu_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (req && !hit) state_nx = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
      ST_WRITEBACK: if (bus.mem_ack_i) state_nx = ST_ALLOCATE;
      ST_ALLOCATE:  if (bus.mem_ack_i) state_nx = ST_FILL;
      ST_FILL:      state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_data   = '0;
    cpu_stall  = 1'b0;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    sram_we    = 1'b0;
    wr_tag     = tag;
    wr_line    = merged_line;
    wr_dirty   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (req && rst_i) begin
          if (hit) begin
            sram_we  = is_store;
            cpu_data = is_store ? 32'd0 : rd_line[wsel*WORD_W +: WORD_W];
          end else begin
            cpu_stall = 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        cpu_stall  = 1'b1;
        mem_enable = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {rd_tag, index, {OFFSET_W{1'b0}}};
      end
      ST_ALLOCATE: begin
        cpu_stall  = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = {tag, index, {OFFSET_W{1'b0}}};
      end
      ST_FILL: begin
        cpu_stall = 1'b1;
        sram_we   = 1'b1;
        wr_line   = fill_buf;
        wr_dirty  = 1'b0;
      end
      default: ;
    endcase
  end

  // The ack is a single-cycle pulse, so the fetched line is captured with it.
  always_ff @(posedge clk_i) begin
    if (state == ST_ALLOCATE && bus.mem_ack_i) fill_buf <= bus.mem_data_i;
  end

  assign bus.cpu_data_o   = cpu_data;
  assign bus.cpu_stall_o  = cpu_stall;
  assign bus.mem_enable_o = mem_enable;
  assign bus.mem_write_o  = mem_write;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = rd_line;
  assign dbg_state        = state;

`ifdef DCACHE_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = (state == ST_IDLE) && req && hit;
  assign miss_evt = (state == ST_IDLE) && req && !hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (hit_evt && (hit_count_o != 32'hFFFF_FFFF))   hit_count_o  <= hit_count_o + 32'd1;
      if (miss_evt && (miss_count_o != 32'hFFFF_FFFF)) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random traffic
// checked against a behavioural cache/backing-memory model.
module tb_dcache_controller;
  import cpu_pkg::*;

  localparam int unsigned NL = 32;
  localparam int unsigned LB = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_controller_if #(.LINE_BITS(LB)) bus ();
  dcache_state_t dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_controller #(.NUM_LINES(NL), .LINE_BITS(LB)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .bus          (bus),
`ifdef DCACHE_STATS_EN
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count),
`endif
    .dbg_state    (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int mem_lat = 3;
  logic force_ack = 1'b0;

  // memory device and observed transactions
  logic [LB-1:0] dev_mem [logic [31:0]];
  logic [32:0]   obs_q[$];
  logic [LB-1:0] obs_line_q[$];
  // reference model: cache contents, backing memory, expected transactions
  logic          m_valid [NL];
  logic          m_dirty [NL];
  logic [21:0]   m_tag   [NL];
  logic [31:0]   m_word  [NL][8];
  logic [LB-1:0] ref_mem [logic [31:0]];
  logic [32:0]   exp_q[$];
  logic [LB-1:0] exp_line_q[$];
  logic [LB-1:0] last_wb_line;
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic logic [LB-1:0] init_line(input logic [31:0] la);
    logic [LB-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  function automatic logic [LB-1:0] backing(input logic [31:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  function automatic logic [LB-1:0] model_line(input int idx);
    logic [LB-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = m_word[idx][w];
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  initial begin : mem_device
    int cnt;
    logic [31:0] a;
    cnt = 0;
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = force_ack;
      if (bus.mem_enable_o === 1'b1) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          a = bus.mem_addr_o;
          bus.mem_ack_i = 1'b1;
          obs_q.push_back({bus.mem_write_o, a});
          if (bus.mem_write_o === 1'b1) begin
            dev_mem[a] = bus.mem_data_o;
            obs_line_q.push_back(bus.mem_data_o);
          end else begin
            bus.mem_data_i = dev_mem.exists(a) ? dev_mem[a] : init_line(a);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input string name, output logic was_miss);
    int idx, w, exp_stall, stall_cyc;
    logic [21:0] tg;
    logic exp_hit, exp_wb;
    logic [31:0] la, vla, exp_data;
    logic [32:0] e, o;
    logic [LB-1:0] el, ol, ln;
    idx = int'(addr[9:5]);
    tg = addr[31:10];
    w = int'(addr[4:2]);
    la = {addr[31:5], 5'b0};
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb = !exp_hit && m_valid[idx] && m_dirty[idx];
    if (exp_wb) begin
      vla = {m_tag[idx], 5'(idx), 5'b0};
      exp_q.push_back({1'b1, vla});
      exp_line_q.push_back(model_line(idx));
      ref_mem[vla] = model_line(idx);
    end
    if (!exp_hit) begin
      exp_q.push_back({1'b0, la});
      ln = backing(la);
      for (int k = 0; k < 8; k++) m_word[idx][k] = ln[k*32 +: 32];
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      m_dirty[idx] = 1'b0;
      exp_misses++;
    end
    exp_hits++;
    exp_stall = exp_hit ? 0 : (exp_wb ? 2 * mem_lat + 2 : mem_lat + 2);
    if (wr) begin
      m_word[idx][w] = wdata;
      m_dirty[idx] = 1'b1;
    end
    exp_data = m_word[idx][w];

    @(negedge clk);
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wdata;
    bus.cpu_MemRead_i = rd;
    bus.cpu_MemWrite_i = wr;
    #1;
    stall_cyc = 0;
    while (bus.cpu_stall_o === 1'b1 && stall_cyc < 200) begin
      stall_cyc++;
      @(negedge clk);
      #1;
    end
    was_miss = (stall_cyc != 0);
    checks++;
    if (stall_cyc != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cyc, exp_stall);
    end
    if (!wr) begin
      checks++;
      if (bus.cpu_data_o !== exp_data) begin
        errors++;
        $display("FAIL %s load_data: got %h expected %h", name, bus.cpu_data_o, exp_data);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s mem_txn: got none expected %h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s mem_txn: got %h expected %h", name, o, e);
        end
      end
    end
    while (exp_line_q.size() != 0) begin
      el = exp_line_q.pop_front();
      checks++;
      if (obs_line_q.size() == 0) begin
        errors++;
        $display("FAIL %s wb_line: got none expected %h", name, el);
      end else begin
        ol = obs_line_q.pop_front();
        last_wb_line = ol;
        if (ol !== el) begin
          errors++;
          $display("FAIL %s wb_line: got %h expected %h", name, ol, el);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || obs_line_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra_mem_txn: got %0d expected 0", name, obs_q.size());
      obs_q.delete();
      obs_line_q.delete();
    end

    @(negedge clk);
    bus.cpu_MemRead_i = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    #1;
    checks++;
    if (bus.cpu_data_o !== 32'd0 || bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_outputs: got data=%h stall=%b expected data=0 stall=0",
               name, bus.cpu_data_o, bus.cpu_stall_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_addr_i = 32'h0000_0040;
    bus.cpu_MemRead_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.cpu_stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b en=%b wr=%b expected 0 0 0",
               bus.cpu_stall_o, bus.mem_enable_o, bus.mem_write_o);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", hit_count, miss_count);
    end
`endif
    bus.cpu_MemRead_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    #1;
    checks++;
    if (bus.cpu_data_o !== 32'd0 || bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got data=%h stall=%b expected 0 0", bus.cpu_data_o, bus.cpu_stall_o);
    end
  endtask

  task automatic test_cold_load();
    logic m;
    mem_lat = 10;
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'd0, "cold_load", m);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL cold_load_miss: got %b expected 1", m);
    end
  endtask

  task automatic test_store_hit();
    logic m;
    mem_lat = 4;
    do_access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, "store_hit", m);
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'd0, "load_after_store", m);
    checks++;
    if (m !== 1'b0) begin
      errors++;
      $display("FAIL load_after_store_hit: got miss=%b expected 0", m);
    end
  endtask

  task automatic test_writeback();
    logic m;
    mem_lat = 4;
    do_access(1'b1, 1'b0, 32'h0000_0444, 32'd0, "conflict_load", m);
    checks++;
    if (last_wb_line[63:32] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wb_word1: got %h expected deadbeef", last_wb_line[63:32]);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic m;
    mem_lat = 10;
    @(negedge clk);
    bus.cpu_addr_i = 32'h0000_0840;
    bus.cpu_MemRead_i = 1'b1;
    bus.cpu_MemWrite_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || dbg_state !== ST_ALLOCATE) begin
      errors++;
      $display("FAIL pre_reset_allocate: got en=%b wr=%b state=%0d expected 1 0 %0d",
               bus.mem_enable_o, bus.mem_write_o, dbg_state, ST_ALLOCATE);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_enable_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: got en=%b stall=%b expected 0 0", bus.mem_enable_o, bus.cpu_stall_o);
    end
    bus.cpu_MemRead_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    obs_q.delete();
    obs_line_q.delete();
    mem_lat = 5;
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'd0, "reload_after_reset", m);
    checks++;
    if (m !== 1'b1) begin
      errors++;
      $display("FAIL reload_misses: got miss=%b expected 1", m);
    end
  endtask

  task automatic test_spurious_ack();
    logic m;
    @(posedge clk);
    #1 force_ack = 1'b1;
    @(negedge clk);
    #1 force_ack = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || bus.mem_enable_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack_state: got state=%0d en=%b stall=%b expected %0d 0 0",
               dbg_state, bus.mem_enable_o, bus.cpu_stall_o, ST_IDLE);
    end
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'd0, "hit_after_spurious_ack", m);
    checks++;
    if (m !== 1'b0) begin
      errors++;
      $display("FAIL hit_after_spurious_ack_latency: got miss=%b expected 0", m);
    end
  endtask

  task automatic test_both_asserted();
    logic m;
    mem_lat = 2;
    do_access(1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678, "read_write_store", m);
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'd0, "read_write_check", m);
  endtask

  task automatic test_random();
    logic m;
    logic [21:0] tags [4];
    logic [21:0] tg;
    logic [4:0] idx;
    logic [2:0] w;
    int op;
    tags[0] = 22'h0;
    tags[1] = 22'h1;
    tags[2] = 22'h155;
    tags[3] = 22'h3F_FFFF;
    for (int n = 0; n < 160; n++) begin
      mem_lat = $urandom_range(1, 5);
      tg = tags[$urandom_range(0, 3)];
      idx = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
      w = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 3);
      do_access((op != 2), (op >= 2), {tg, idx, w, 2'b00}, $urandom, "random", m);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    model_clear();
    test_reset();
    test_cold_load();
    test_store_hit();
    test_writeback();
    test_reset_mid_miss();
    test_spurious_ack();
    test_both_asserted();
    test_random();
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL stats_counts: got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
    $display("info: modelled hits=%0d misses=%0d since last reset", exp_hits, exp_misses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
